// File: rtl/audio_capture_ctrl.sv
// audio_capture_ctrl: enable-gated warm-up sequencer feeding a stereo PCM FWFT FIFO.
// Optional AUDIO_CAPTURE_MUTE_EN adds a mute input that zeroes captured frames.
module audio_capture_ctrl #(
    parameter int DEPTH  = 4,
    parameter int WARMUP = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               stb_pcm,
    input  logic signed [15:0] pcm_l,
    input  logic signed [15:0] pcm_r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_l,
    output logic signed [15:0] out_r,
    output logic               ovf,
    input  logic               ovf_clr,
`ifdef AUDIO_CAPTURE_MUTE_EN
    input  logic               mute,
`endif
    output logic               running
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        running_q, ovf_q, ovf_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] wdata;
    logic        empty, full, pop, push_req, wr;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) state_d = IDLE;
        else begin
            case (state_q)
                IDLE: begin
                    state_d = WARM;
                    cnt_d   = '0;
                end
                WARM: if (stb_pcm) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (cnt_q + 8'd1 == 8'(WARMUP)) ? RUN : WARM;
                end
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end
    assign empty    = wptr_q == rptr_q;
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop      = !empty && out_ready;
    assign push_req = en && stb_pcm && state_q == RUN;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr       = push_req && (!full || pop);
`ifdef AUDIO_CAPTURE_MUTE_EN
    assign wdata    = mute ? 32'd0 : {pcm_l, pcm_r};
`else
    assign wdata    = {pcm_l, pcm_r};
`endif
    assign wptr_d   = wr ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
    assign ovf_d    = (push_req && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            running_q <= state_d == RUN;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end
    // Storage is reset so the head outputs read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end
    assign out_valid      = !empty;
    assign {out_l, out_r} = mem_q[rptr_q[AW-1:0]];
    assign ovf            = ovf_q;
    assign running        = running_q;
endmodule

// File: tb/tb_audio_capture_ctrl.sv
// tb_audio_capture_ctrl: directed stimulus with a queue scoreboard and a decoupled output monitor.
module tb_audio_capture_ctrl;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               stb_pcm = 1'b0;
    logic signed [15:0] pcm_l = '0;
    logic signed [15:0] pcm_r = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic               ovf;
    logic               ovf_clr = 1'b0;
    logic               running;
`ifdef AUDIO_CAPTURE_MUTE_EN
    logic               mute = 1'b0;
`endif
    int errors = 0;
    int checks = 0;
    logic [31:0] sb [$];

    audio_capture_ctrl #(.DEPTH(4), .WARMUP(8)) dut (
        .clk(clk), .rst(rst), .en(en), .stb_pcm(stb_pcm),
        .pcm_l(pcm_l), .pcm_r(pcm_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_l(out_l), .out_r(out_r),
        .ovf(ovf), .ovf_clr(ovf_clr),
`ifdef AUDIO_CAPTURE_MUTE_EN
        .mute(mute),
`endif
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_frame", {out_l, out_r}, 32'hxxxx_xxxx);
            else chk("frame", {out_l, out_r}, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int k, input bit accepted);
        stb_pcm = 1'b1;
        pcm_l   = 16'(k);
        pcm_r   = 16'(-k);
        if (accepted) sb.push_back({16'(k), 16'(-k)});
        tick();
        stb_pcm = 1'b0;
        tick();
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        chk(name, {30'd0, sb.size() != 0, out_valid}, 32'd0);
    endtask

    initial begin
        #1;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", {out_l, out_r}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        chk("reset_running", {31'd0, running}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        // 1: warm-up discards eight strobes
        out_ready = 1'b1;
        en = 1'b1;
        tick();
        for (int k = 1; k <= 12; k++) begin
            strobe(k, k > 8);
            if (k == 7) chk("running_before_last_warm", {31'd0, running}, 32'd0);
            if (k == 8) chk("running_after_warm", {31'd0, running}, 32'd1);
        end
        wait_empty("warmup_drain");
        // 2: fill and overflow
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            strobe(k, k <= 4);
            if (k == 4) chk("ovf_at_full", {31'd0, ovf}, 32'd0);
            if (k == 5) chk("ovf_set", {31'd0, ovf}, 32'd1);
        end
        chk("head_after_overflow", {out_l, out_r}, {16'd1, 16'hffff});
        out_ready = 1'b1;
        wait_empty("overflow_drain");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clear", {31'd0, ovf}, 32'd0);
        // 3: full FIFO with simultaneous pop and push
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) strobe(k, 1'b1);
        out_ready = 1'b1;
        strobe(5, 1'b1);
        chk("ovf_full_pop", {31'd0, ovf}, 32'd0);
        wait_empty("full_pop_drain");
        // 4: disable mid-run, then warm up again
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) strobe(k, 1'b1);
        en = 1'b0;
        strobe(4, 1'b0);
        chk("running_after_disable", {31'd0, running}, 32'd0);
        out_ready = 1'b1;
        wait_empty("disable_drain");
        en = 1'b1;
        tick();
        for (int i = 1; i <= 9; i++) begin
            strobe(29 + i, i == 9);
            if (i == 7) chk("rewarm_running_low", {31'd0, running}, 32'd0);
            if (i == 8) chk("rewarm_running_high", {31'd0, running}, 32'd1);
        end
        wait_empty("rewarm_drain");
        // 5: asynchronous reset with frames buffered and ovf set
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) strobe(k, k <= 4);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("pre_reset_state", {29'd0, out_valid, ovf, running}, 32'd7);
        #2;
        rst = 1'b1;
        en = 1'b0;
        #1;
        chk("async_reset_flags", {29'd0, out_valid, ovf, running}, 32'd0);
        chk("async_reset_data", {out_l, out_r}, 32'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
`ifdef AUDIO_CAPTURE_MUTE_EN
        // 6: muted strobes push zero frames
        out_ready = 1'b1;
        en = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) strobe(i, 1'b0);
        mute = 1'b1;
        stb_pcm = 1'b1; pcm_l = 16'd20; pcm_r = -16'sd20; sb.push_back(32'd0);
        tick(); stb_pcm = 1'b0; tick();
        stb_pcm = 1'b1; pcm_l = 16'd21; pcm_r = -16'sd21; sb.push_back(32'd0);
        tick(); stb_pcm = 1'b0; tick();
        mute = 1'b0;
        strobe(22, 1'b1);
        wait_empty("mute_drain");
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/audio_capture_ctrl.md
# audio_capture_ctrl

Sequencer and buffer between the stereo PDM filter datapath and the audio consumer. Gates capture with an enable, discards the first `WARMUP` PCM samples after enable while the CIC and DC filters settle, and captures left/right 16-bit PCM pairs on `stb_pcm`. Frames go into a small FIFO and are presented on a valid/ready stream. The block sits downstream of the clock generator and two filter instances, one per channel, and upstream of any audio sink (I2S, DMA, USB).

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in stereo frames; power of two, at least 2.
- `WARMUP`, 8: number of `stb_pcm` pulses discarded after entering warm-up; range 1..255.

Ports:
- `clk`, input, 1: system clock; all logic on posedge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `en`, input, 1: capture enable, level.
- `stb_pcm`, input, 1: one-cycle PCM strobe from the clock generator.
- `pcm_l`, input, 16 signed: left filter output; valid in the cycle `stb_pcm` is high.
- `pcm_r`, input, 16 signed: right filter output; valid in the cycle `stb_pcm` is high.
- `out_valid`, output, 1: head frame is valid.
- `out_ready`, input, 1: consumer accepts the head frame.
- `out_l`, output, 16 signed: head frame, left sample.
- `out_r`, output, 16 signed: head frame, right sample.
- `ovf`, output, 1: sticky overflow flag.
- `ovf_clr`, input, 1: clears `ovf`.
- `running`, output, 1: high in state RUN.

## Operation
- States: IDLE, WARM, RUN. Reset state is IDLE.
- IDLE → WARM when `en`=1. The warm-up counter loads 0.
- WARM: each `stb_pcm` increments the counter, and the sample is discarded. On the strobe that brings the count to `WARMUP`, move to RUN. That strobe's sample is still discarded.
- RUN: each `stb_pcm` pushes {`pcm_l`,`pcm_r`} into the FIFO.
- Any state → IDLE on the cycle after `en` samples 0. This takes priority over every other transition. A strobe in the same cycle that `en`=0 is not pushed.
- FIFO contents survive IDLE and WARM and keep draining. The FIFO is emptied only by `rst`.
- Pop happens when `out_valid && out_ready`. The outputs are first-word-fall-through from FIFO storage.
- Push into a full FIFO without a simultaneous pop: the frame is dropped and `ovf` sets. Stored contents are unchanged.
- Push into a full FIFO with a simultaneous pop: the push is accepted, occupancy stays at `DEPTH`, and `ovf` does not set.
- `ovf_clr` and a new overflow in the same cycle: `ovf` stays 1 (set wins).
- Read and write pointers are log2(`DEPTH`)+1 bits and wrap naturally. Full means the MSBs differ and the rest are equal.
- No arithmetic on the sample data; samples pass bit-exact.

## Timing
- Reset values: `out_valid`=0, `out_l`=0, `out_r`=0, `ovf`=0, `running`=0, pointers 0, state IDLE.
- `en` rising in cycle N: state is WARM in cycle N+1. The first counted strobe can occur in N+1.
- Strobe pushed in cycle N into an empty FIFO: `out_valid`=1 with that frame in cycle N+1.
- Pop in cycle N: the next frame, or `out_valid`=0, appears in cycle N+1.
- `running` is registered and reflects the state. It rises in the cycle after the last warm-up strobe.
- `rst` asserted mid-operation: all outputs go to reset values immediately (asynchronously). Frames in flight are lost.
- `out_l`/`out_r` are stable while `out_valid && !out_ready`.

## Configuration
- `AUDIO_CAPTURE_MUTE_EN` defined: adds input port `mute` (1 bit, placed after `ovf_clr`). While `mute`=1 in RUN, strobes push frames of 0/0 instead of `pcm_l`/`pcm_r`. Frame rate, FIFO behaviour and overflow behaviour are unchanged.
- Macro undefined: the `mute` port does not exist and samples always pass through.

## Test plan
1. Warm-up discard:
   - Stimulus: `WARMUP`=8, `en`=1, 12 strobes with `pcm_l`=k, `pcm_r`=-k for k=1..12, `out_ready`=1.
   - Response: the consumer receives exactly k=9..12 in order. `running` rises after strobe 8.
2. Fill and overflow:
   - Stimulus: `DEPTH`=4, RUN, `out_ready`=0, strobes with k=1..6.
   - Response: FIFO holds 1..4. `ovf`=1 after strobe 5. Draining yields 1,2,3,4, then `out_valid`=0.
3. Full with simultaneous pop:
   - Stimulus: FIFO full with 1..4; assert `out_ready` on the same cycle as strobe k=5.
   - Response: `ovf` stays 0. Drain yields 2,3,4,5.
4. Disable mid-run:
   - Stimulus: 3 frames buffered; `en`=0 on a strobe cycle.
   - Response: that strobe is not pushed and the state is IDLE. The 3 frames drain. Re-enable restarts an 8-strobe warm-up.
5. Async reset:
   - Stimulus: `rst` pulse with 2 frames buffered and `ovf`=1, with no clock edge.
   - Response: `out_valid`, `ovf` and `running` all read 0 immediately.
6. Mute (macro defined):
   - Stimulus: `mute`=1 for strobes k=20..21 in RUN.
   - Response: output frames are 0/0 twice, then k=22 passes unchanged.
